// File: rtl/wb_initiator_seq.sv
// wb_initiator_seq: Wishbone B4 classic single-transfer initiator.
// One accepted command becomes one bus cycle and one ordered response.
module wb_initiator_seq #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [AW-1:0]   cmd_adr_i,
    input  logic [DW-1:0]   cmd_dat_i,
    input  logic [DW/8-1:0] cmd_sel_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DW-1:0]   rsp_dat_o,
    output logic            rsp_err_o,
    output logic            busy_o,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    input  logic            wbm_ack_i,
    input  logic [DW-1:0]   wbm_dat_i
);

    localparam int              SEL_W   = DW / 8;
    localparam logic            TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    logic             cmd_ready_d;
    logic             cyc_d;
    logic             we_d;
    logic [SEL_W-1:0] sel_d;
    logic [AW-1:0]    adr_d;
    logic [DW-1:0]    dat_d;
    logic             rsp_valid_d;
    logic [DW-1:0]    rsp_dat_d;
    logic             rsp_err_d;

    assign busy_o    = (state_q != IDLE);
    assign wbm_stb_o = wbm_cyc_o;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_ready_d = cmd_ready_o;
        cyc_d       = wbm_cyc_o;
        we_d        = wbm_we_o;
        sel_d       = wbm_sel_o;
        adr_d       = wbm_adr_o;
        dat_d       = wbm_dat_o;
        rsp_valid_d = rsp_valid_o;
        rsp_dat_d   = rsp_dat_o;
        rsp_err_d   = rsp_err_o;

        unique case (state_q)
            IDLE: begin
                // Ready rises one edge after reset release.
                cmd_ready_d = 1'b1;
                if (cmd_valid_i && cmd_ready_o) begin
                    cmd_ready_d = 1'b0;
                    cyc_d       = 1'b1;
                    we_d        = cmd_we_i;
                    sel_d       = cmd_sel_i;
                    adr_d       = {cmd_adr_i[AW-1:2], 2'b00};
                    dat_d       = cmd_dat_i;
                    cnt_d       = '0;
                    state_d     = BUS;
                end
            end
            BUS: begin
                cnt_d = cnt_q + TO_W'(1);
                if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_dat_d   = wbm_we_o ? '0 : wbm_dat_i;
                    state_d     = RESP;
                end else if (TO_EN && cnt_q == TO_LAST) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = '0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_ready_o <= 1'b0;
            wbm_cyc_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= '0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_o <= cmd_ready_d;
            wbm_cyc_o   <= cyc_d;
            wbm_we_o    <= we_d;
            wbm_sel_o   <= sel_d;
            wbm_adr_o   <= adr_d;
            wbm_dat_o   <= dat_d;
            rsp_valid_o <= rsp_valid_d;
            rsp_dat_o   <= rsp_dat_d;
            rsp_err_o   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_wb_initiator_seq.sv
// tb_wb_initiator_seq: directed and random checks of wb_initiator_seq
// against a word-memory reference and a wait-state slave.
module tb_wb_initiator_seq;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        busy;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_o;
    logic        ack;
    logic [31:0] dat_i;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ref_mem [16];
    logic [31:0] slv_mem [16];
    int          rdy_wait;
    int          last_len;
    logic [31:0] last_dat;
    logic        last_err;
    logic [31:0] last_adr;

    always #5 clk = ~clk;

    wb_initiator_seq #(
        .AW(32), .DW(32), .TO_W(8), .TIMEOUT(TMO)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_we_i   (cmd_we),
        .cmd_adr_i  (cmd_adr),
        .cmd_dat_i  (cmd_dat),
        .cmd_sel_i  (cmd_sel),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_dat_o  (rsp_dat),
        .rsp_err_o  (rsp_err),
        .busy_o     (busy),
        .wbm_cyc_o  (cyc),
        .wbm_stb_o  (stb),
        .wbm_we_o   (we),
        .wbm_sel_o  (sel),
        .wbm_adr_o  (adr),
        .wbm_dat_o  (dat_o),
        .wbm_ack_i  (ack),
        .wbm_dat_i  (dat_i)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0]  s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(negedge clk)
        if (rst_n) chk("stb_eq_cyc", 64'(stb), 64'(cyc));

    // One command end to end; waits = slave wait states before ack.
    task automatic xfer(input logic c_we, input logic [31:0] c_adr,
                        input logic [31:0] c_dat, input logic [3:0] c_sel,
                        input int waits, input int hold, input logic chain);
        logic [31:0] exp_dat;
        logic [31:0] exp_adr;
        logic        exp_err;
        int          exp_len;
        int          idx;
        int          n;
        idx     = int'(c_adr[5:2]);
        exp_adr = {c_adr[31:2], 2'b00};
        exp_err = (waits >= TMO);
        exp_len = exp_err ? TMO : waits + 1;
        exp_dat = (c_we || exp_err) ? 32'h0 : ref_mem[idx];
        if (c_we && !exp_err) ref_mem[idx] = merge(ref_mem[idx], c_dat, c_sel);

        cmd_we    = c_we;
        cmd_adr   = c_adr;
        cmd_dat   = c_dat;
        cmd_sel   = c_sel;
        cmd_valid = 1'b1;
        rdy_wait  = 0;
        while (!cmd_ready && rdy_wait < 10) begin
            step();
            rdy_wait++;
        end
        chk("cmd_ready", 64'(cmd_ready), 64'(1'b1));
        step();
        cmd_valid = 1'b0;
        cmd_we    = 1'($urandom);
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        cmd_sel   = 4'($urandom);

        n = 0;
        while (cyc && n < 20) begin
            n++;
            last_adr = adr;
            chk("bus_adr", 64'(adr), 64'(exp_adr));
            chk("bus_we", 64'(we), 64'(c_we));
            chk("bus_sel", 64'(sel), 64'(c_sel));
            chk("bus_dat", 64'(dat_o), 64'(c_dat));
            chk("bus_rdy", 64'(cmd_ready), 64'(1'b0));
            chk("bus_rspv", 64'(rsp_valid), 64'(1'b0));
            chk("bus_busy", 64'(busy), 64'(1'b1));
            if (n == waits + 1) begin
                ack   = 1'b1;
                dat_i = slv_mem[int'(adr[5:2])];
                if (we)
                    slv_mem[int'(adr[5:2])] =
                        merge(slv_mem[int'(adr[5:2])], dat_o, sel);
            end else begin
                ack   = 1'b0;
                dat_i = $urandom;
            end
            step();
        end
        ack = 1'b0;
        last_len = n;
        last_dat = rsp_dat;
        last_err = rsp_err;
        chk("cyc_len", 64'(n), 64'(exp_len));
        chk("rsp_valid", 64'(rsp_valid), 64'(1'b1));
        chk("rsp_dat", 64'(rsp_dat), 64'(exp_dat));
        chk("rsp_err", 64'(rsp_err), 64'(exp_err));

        for (int h = 0; h < hold; h++) begin
            if (chain) cmd_valid = 1'b1;
            ack   = 1'($urandom);
            dat_i = $urandom;
            step();
            chk("hold_valid", 64'(rsp_valid), 64'(1'b1));
            chk("hold_dat", 64'(rsp_dat), 64'(exp_dat));
            chk("hold_err", 64'(rsp_err), 64'(exp_err));
            chk("hold_rdy", 64'(cmd_ready), 64'(1'b0));
            chk("hold_cyc", 64'(cyc), 64'(1'b0));
        end
        ack       = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("post_valid", 64'(rsp_valid), 64'(1'b0));
        chk("post_rdy", 64'(cmd_ready), 64'(1'b1));
        chk("post_busy", 64'(busy), 64'(1'b0));
        chk("post_dat", 64'(rsp_dat), 64'(exp_dat));
        chk("post_err", 64'(rsp_err), 64'(exp_err));
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b0;
        ack       = 1'b0;
        dat_i     = '0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            slv_mem[i] = ref_mem[i];
        end

        repeat (3) step();
        chk("rst_rdy", 64'(cmd_ready), 64'(1'b0));
        chk("rst_cyc", 64'(cyc), 64'(1'b0));
        chk("rst_stb", 64'(stb), 64'(1'b0));
        chk("rst_bus", 64'({we, sel, adr, dat_o}), 64'(0));
        chk("rst_rsp", 64'({rsp_valid, rsp_err, rsp_dat}), 64'(0));
        chk("rst_busy", 64'(busy), 64'(1'b0));
        rst_n = 1'b1;
        step();
        chk("rel_rdy", 64'(cmd_ready), 64'(1'b1));

        xfer(1'b1, 32'h3000_0007, 32'hA5A5_0F0F, 4'hF, 2, 0, 1'b0);
        chk("t2_adr", 64'(last_adr), 64'(32'h3000_0004));
        chk("t2_len", 64'(last_len), 64'(3));
        chk("t2_dat", 64'(last_dat), 64'(0));
        chk("t2_err", 64'(last_err), 64'(0));

        ref_mem[2] = 32'h1234_5678;
        slv_mem[2] = 32'h1234_5678;
        xfer(1'b0, 32'h3000_0008, 32'h0, 4'hF, 0, 0, 1'b0);
        chk("t3_len", 64'(last_len), 64'(1));
        chk("t3_dat", 64'(last_dat), 64'(32'h1234_5678));
        chk("t3_err", 64'(last_err), 64'(0));

        xfer(1'b0, 32'h3000_000C, 32'h0, 4'hF, 99, 0, 1'b0);
        chk("t4_len", 64'(last_len), 64'(4));
        chk("t4_err", 64'(last_err), 64'(1));
        chk("t4_dat", 64'(last_dat), 64'(0));
        xfer(1'b0, 32'h3000_000C, 32'h0, 4'hF, 3, 0, 1'b0);
        chk("t4b_len", 64'(last_len), 64'(4));
        chk("t4b_err", 64'(last_err), 64'(0));

        xfer(1'b1, 32'h3000_0010, 32'hCAFE_F00D, 4'h5, 1, 5, 1'b1);
        xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, 0, 0, 1'b0);
        chk("t5_accept", 64'(rdy_wait), 64'(0));

        cmd_we    = 1'b1;
        cmd_adr   = 32'h3000_0014;
        cmd_dat   = 32'hDEAD_0001;
        cmd_sel   = 4'hF;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        chk("t1_inbus", 64'(cyc), 64'(1'b1));
        rst_n = 1'b0;
        step();
        chk("t1_cyc", 64'(cyc), 64'(1'b0));
        chk("t1_stb", 64'(stb), 64'(1'b0));
        chk("t1_rspv", 64'(rsp_valid), 64'(1'b0));
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("t1_rdy", 64'(cmd_ready), 64'(1'b1));
        chk("t1_norsp", 64'(rsp_valid), 64'(1'b0));

        for (int k = 0; k < 1000; k++)
            xfer(1'($urandom), 32'h3000_0000 | 32'($urandom_range(0, 63)),
                 $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 6), $urandom_range(0, 2),
                 1'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
